// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: the received byte, its error flags and the
// valid/ready handshake toward the consumer.
//   master : the receiver (drives byte, flags, valid; samples ready)
//   slave  : the consumer (samples byte, flags, valid; drives ready)
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    modport master (
        output data_out,
        output data_out_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver. Synchronises the asynchronous rx line, finds the start bit,
// samples data LSB-first at bit centres, checks parity and the first stop bit
// and hands each byte with its error flags to a valid/ready consumer.
// The FSM resynchronises at the first stop-bit centre, so extra stop time is
// simply idle line.
// Optional feature: define UART_RX_MAJORITY_EN to decide every bit by a
// 2-of-3 vote of rx_s at cnt == N/2-1, N/2, N/2+1 (decision one clock later).
module uart_rx #(
    parameter int system_clk = 50_000_000,
    parameter int band_rate  = 9600,
    parameter int data_bits  = 8,
    parameter int check_mode = 1,
    parameter int stop_mode  = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_en,
    input  logic      rx,
    output logic      busy,
    uart_rx_if.master rx_out
);

    localparam int N     = system_clk / band_rate;
    localparam int CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(N / 2);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(N / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(N / 2 + 1);
`else
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_MID;
`endif
    localparam logic [2:0] LAST_BIT   = 3'(data_bits - 1);
    localparam logic [2:0] CHK        = 3'(check_mode);
    localparam logic       HAS_PARITY = (check_mode != 0);

    // Reject frame formats the receiver cannot handle at elaboration time.
    generate
        if (N < 8 || data_bits < 5 || data_bits > 8 || check_mode < 0 || check_mode > 4 ||
            stop_mode < 0 || stop_mode > 2) begin : g_bad_param
            $error("uart_rx: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        START  = 6'b000010,
        DATA   = 6'b000100,
        PARITY = 6'b001000,
        STOP   = 6'b010000,
        BREAK  = 6'b100000
    } state_t;

    // Parity bit the transmitter should have sent for the given data.
    function automatic logic parity_expect(input logic [7:0] d);
        case (CHK)
            3'd1:    parity_expect = ^d;
            3'd2:    parity_expect = ~^d;
            3'd3:    parity_expect = 1'b0;
            3'd4:    parity_expect = 1'b1;
            default: parity_expect = 1'b0;
        endcase
    endfunction

    // 2-of-3 vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

    logic             sync_1_r;
    logic             rx_s_r;
    logic             rx_prev_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             p_flag_r;
    logic [7:0]       data_out_r;
    logic             valid_r;
    logic             perr_r;
    logic             ferr_r;
    logic             ovr_r;
    logic             busy_r;
    logic             sample_tick_s;
    logic             bit_val_s;
    logic             fall_s;
    logic             stop_done_s;
    logic             commit_ok_s;
`ifdef UART_RX_MAJORITY_EN
    logic             maj_early_r;
    logic             maj_mid_r;
`endif

    assign sample_tick_s = (cnt_r == CNT_DECIDE);
    assign fall_s        = rx_prev_r & ~rx_s_r;
`ifdef UART_RX_MAJORITY_EN
    assign bit_val_s     = majority3(maj_early_r, maj_mid_r, rx_s_r);
`else
    assign bit_val_s     = rx_s_r;
`endif
    assign stop_done_s   = rx_en & (state_r == STOP) & sample_tick_s;
    assign commit_ok_s   = ~valid_r | rx_out.data_out_ready;

    // Two-flop synchroniser for rx plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1_r  <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync_1_r  <= rx;
            rx_s_r    <= sync_1_r;
            rx_prev_r <= rx_s_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a disabled receiver is forced back to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (!rx_en) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) state_next_s = START;
                    else        state_next_s = IDLE;
                end
                START: begin
                    if (sample_tick_s) state_next_s = bit_val_s ? IDLE : DATA;
                    else               state_next_s = START;
                end
                DATA: begin
                    if (sample_tick_s && (bit_idx_r == LAST_BIT)) begin
                        if (HAS_PARITY) state_next_s = PARITY;
                        else            state_next_s = STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end
                PARITY: begin
                    if (sample_tick_s) state_next_s = STOP;
                    else               state_next_s = PARITY;
                end
                STOP: begin
                    if (sample_tick_s) state_next_s = bit_val_s ? IDLE : BREAK;
                    else               state_next_s = STOP;
                end
                BREAK: begin
                    if (rx_s_r) state_next_s = IDLE;
                    else        state_next_s = BREAK;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Bit-period counter: held at zero in IDLE so it starts at 0 on the first START cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (state_r == IDLE) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Capture the two earlier votes around each bit centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            maj_early_r <= 1'b1;
            maj_mid_r   <= 1'b1;
        end else begin
            if (cnt_r == CNT_EARLY) maj_early_r <= rx_s_r;
            if (cnt_r == CNT_MID)   maj_mid_r   <= rx_s_r;
        end
    end
`endif

    // Frame assembly: data shift-in (LSB first) and parity comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            p_flag_r  <= 1'b0;
        end else if (state_r == START) begin
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            p_flag_r  <= 1'b0;
        end else if ((state_r == DATA) && sample_tick_s) begin
            shift_r[bit_idx_r] <= bit_val_s;
            bit_idx_r          <= bit_idx_r + 3'd1;
        end else if ((state_r == PARITY) && sample_tick_s) begin
            p_flag_r <= bit_val_s ^ parity_expect(shift_r);
        end
    end

    // Holding register, valid/ready handshake and one-cycle overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= 8'h00;
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            ovr_r <= 1'b0;
            if (stop_done_s) begin
                if (commit_ok_s) begin
                    data_out_r <= shift_r;
                    perr_r     <= p_flag_r;
                    ferr_r     <= ~bit_val_s;
                    valid_r    <= 1'b1;
                end else begin
                    ovr_r <= 1'b1;
                end
            end else if (valid_r && rx_out.data_out_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    // Busy flag: high whenever the FSM is outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
        end
    end

    assign busy                  = busy_r;
    assign rx_out.data_out       = data_out_r;
    assign rx_out.data_out_valid = valid_r;
    assign rx_out.parity_err     = perr_r;
    assign rx_out.frame_err      = ferr_r;
    assign rx_out.overrun_err    = ovr_r;

endmodule
